// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data_mem on the core's
// data-memory request bus. TXDATA stores feed a circular FIFO that a small
// FSM drains onto uart_tx_o; STATUS and BAUD_DIV are readable in the request cycle.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_mem_req_i,
   input  logic [31:0] data_mem_addr_i,
   input  logic        data_mem_wr_i,
   input  logic [31:0] data_mem_wr_data_i,
   input  logic [1:0]  data_mem_byte_en_i,
   output logic [31:0] data_mem_rd_data_o,
   output logic        uart_sel_o,
   output logic        uart_tx_o,
   output logic        tx_empty_irq_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   // bus decode
   logic       hit;
   logic [1:0] offset;
   logic       push_req;
   logic       wr_status;
   logic       wr_baud;

   // FIFO and control registers
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push_ok;
   logic          pop;
   logic          overflow;
   logic [15:0]   baud_div;

   // transmit FSM
   state_t      state, state_d;
   logic [15:0] bit_cnt, bit_cnt_d;
   logic [2:0]  bit_idx, bit_idx_d;
   logic [7:0]  shift, shift_d;
   logic [15:0] bit_len, bit_len_d;
   logic        tx_empty_irq;

   logic [6:0]  count7;
   logic [31:0] status_word;
   logic        unused_bits;

   assign hit        = data_mem_req_i && (data_mem_addr_i[31:4] == BASE_ADDR[31:4]);
   assign offset     = data_mem_addr_i[3:2];
   assign uart_sel_o = hit;

   assign push_req  = hit && data_mem_wr_i && (offset == 2'd0);
   assign wr_status = hit && data_mem_wr_i && (offset == 2'd1);
   assign wr_baud   = hit && data_mem_wr_i && (offset == 2'd2) &&
                      ((data_mem_byte_en_i == 2'b01) || (data_mem_byte_en_i == 2'b10));

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
   assign push_ok = push_req && (!full || pop);

   assign unused_bits = ^{data_mem_addr_i[1:0], data_mem_wr_data_i[31:16]};

   // FIFO pointers, occupancy, sticky overflow and the baud divisor register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         baud_div <= DEFAULT_DIV;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (wr_status && data_mem_wr_data_i[3])
            overflow <= 1'b0;
         if (wr_baud) baud_div <= data_mem_wr_data_i[15:0];
      end
   end

   // FIFO storage; pointers alone define which entries are valid
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= data_mem_wr_data_i[7:0];
   end

   // next-state logic: each bit is held for bit_len cycles by a down-counter
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      bit_idx_d = bit_idx;
      shift_d   = shift;
      bit_len_d = bit_len;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = fifo_mem[rd_ptr];
               bit_len_d = (baud_div == 16'd0) ? 16'd1 : baud_div;
               bit_cnt_d = bit_len_d - 16'd1;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            if (bit_cnt == 16'd0) begin
               bit_cnt_d = bit_len - 16'd1;
               bit_idx_d = 3'd0;
               state_d   = ST_DATA;
            end else begin
               bit_cnt_d = bit_cnt - 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_cnt == 16'd0) begin
               bit_cnt_d = bit_len - 16'd1;
               shift_d   = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) state_d = ST_STOP;
               else                 bit_idx_d = bit_idx + 3'd1;
            end else begin
               bit_cnt_d = bit_cnt - 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_cnt == 16'd0) state_d = ST_IDLE;
            else                  bit_cnt_d = bit_cnt - 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM control state and the registered empty interrupt
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         bit_idx      <= '0;
         tx_empty_irq <= 1'b1;
      end else begin
         state        <= state_d;
         bit_cnt      <= bit_cnt_d;
         bit_idx      <= bit_idx_d;
         tx_empty_irq <= empty && (state_d == ST_IDLE);
      end
   end

   // frame data and the per-frame bit length shadow (only read outside IDLE)
   always_ff @(posedge clk) begin
      shift   <= shift_d;
      bit_len <= bit_len_d;
   end

   assign uart_tx_o      = (state == ST_START) ? 1'b0 :
                           (state == ST_DATA)  ? shift[0] : 1'b1;
   assign tx_empty_irq_o = tx_empty_irq;

   assign count7      = 7'(count);
   assign status_word = {17'h0, count7, 4'h0, overflow, (state != ST_IDLE), empty, full};

   // same-cycle read mux; zero whenever the access is not a load hitting the window
   always_comb begin
      data_mem_rd_data_o = 32'h0;
      if (hit && !data_mem_wr_i) begin
         case (offset)
            2'd1:    data_mem_rd_data_o = status_word;
            2'd2:    data_mem_rd_data_o = {16'h0, baud_div};
            default: data_mem_rd_data_o = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed bus sequences plus random payloads, with a
// frame-level serial receiver model that decodes uart_tx_o independently.
module tb_mmio_uart_tx;

   localparam logic [31:0] A_TX   = 32'h1000_0000;
   localparam logic [31:0] A_ST   = 32'h1000_0004;
   localparam logic [31:0] A_BAUD = 32'h1000_0008;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        data_mem_req_i;
   logic [31:0] data_mem_addr_i;
   logic        data_mem_wr_i;
   logic [31:0] data_mem_wr_data_i;
   logic [1:0]  data_mem_byte_en_i;
   logic [31:0] data_mem_rd_data_o;
   logic        uart_sel_o;
   logic        uart_tx_o;
   logic        tx_empty_irq_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int wr_cyc;

   // receiver model state
   bit         rx_en    = 1'b0;
   bit         rx_act   = 1'b0;
   int         model_bl = 1;
   int         rx_bl, rx_pos, rx_t0;
   int         rx_err   = 0;
   logic       rx_smp [0:1023];
   logic [7:0] rx_bytes[$];
   int         rx_start[$];
   int         rx_base  = 0;
   int         err_base = 0;
   logic [7:0] exp_q[$];

   mmio_uart_tx #(
      .BASE_ADDR   (32'h1000_0000),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd868)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .data_mem_req_i     (data_mem_req_i),
      .data_mem_addr_i    (data_mem_addr_i),
      .data_mem_wr_i      (data_mem_wr_i),
      .data_mem_wr_data_i (data_mem_wr_data_i),
      .data_mem_byte_en_i (data_mem_byte_en_i),
      .data_mem_rd_data_o (data_mem_rd_data_o),
      .uart_sel_o         (uart_sel_o),
      .uart_tx_o          (uart_tx_o),
      .tx_empty_irq_o     (tx_empty_irq_o)
   );

   // 100 MHz clock and cycle index
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // decode a captured frame: start low, 8 data bits LSB first, stop high, each bit_len wide
   task automatic rx_finish();
      logic [7:0] b;
      logic       v;
      b = '0;
      for (int k = 0; k < 10; k++) begin
         v = rx_smp[k*rx_bl];
         for (int j = 1; j < rx_bl; j++)
            if (rx_smp[k*rx_bl+j] !== v) rx_err++;
         if (k == 0 && v !== 1'b0) rx_err++;
         if (k == 9 && v !== 1'b1) rx_err++;
         if (k >= 1 && k <= 8) b[k-1] = v;
      end
      rx_bytes.push_back(b);
      rx_start.push_back(rx_t0);
   endtask

   // serial receiver: samples the line mid-cycle and captures 10*bit_len samples per frame
   always @(negedge clk) begin
      if (!rx_en) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (uart_tx_o === 1'b0) begin
            rx_act    = 1'b1;
            rx_bl     = model_bl;
            rx_t0     = cyc;
            rx_smp[0] = 1'b0;
            rx_pos    = 1;
         end
      end else begin
         if (rx_pos < 1024) rx_smp[rx_pos] = uart_tx_o;
         rx_pos++;
         if (rx_pos >= 10*rx_bl) begin
            rx_finish();
            rx_act = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic idle_to(input int t);
      while (cyc < t) begin @(posedge clk); #1; end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] be);
      data_mem_req_i = 1'b1; data_mem_addr_i = a; data_mem_wr_i = 1'b1;
      data_mem_wr_data_i = d; data_mem_byte_en_i = be; wr_cyc = cyc;
      @(posedge clk); #1;
      data_mem_req_i = 1'b0; data_mem_wr_i = 1'b0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic s);
      data_mem_req_i = 1'b1; data_mem_addr_i = a; data_mem_wr_i = 1'b0;
      data_mem_byte_en_i = 2'b10;
      #1;
      d = data_mem_rd_data_o; s = uart_sel_o;
      @(posedge clk); #1;
      data_mem_req_i = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        s;
      bus_rd(a, d, s);
      check(tag, d, exp);
   endtask

   task automatic rx_mark();
      rx_base  = rx_bytes.size();
      err_base = rx_err;
   endtask

   task automatic wait_rx(input string tag, input int n, input int budget);
      int c = 0;
      while ((rx_bytes.size() - rx_base) < n && c < budget) begin @(posedge clk); #1; c++; end
      check({tag, "_rx_in_time"}, 32'(rx_bytes.size() - rx_base), 32'(n));
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int c = 0;
      while (tx_empty_irq_o !== 1'b1 && c < budget) begin @(posedge clk); #1; c++; end
      check({tag, "_idle_irq"}, 32'(tx_empty_irq_o), 32'd1);
   endtask

   // every received byte must match the queue in order; consecutive frame starts spaced by gap
   task automatic compare_rx(input string tag, input int gap);
      int n;
      n = rx_bytes.size() - rx_base;
      check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < n; k++)
         check($sformatf("%s_byte%0d", tag, k), 32'(rx_bytes[rx_base+k]), 32'(exp_q[k]));
      for (int k = 1; k < n; k++)
         check($sformatf("%s_gap%0d", tag, k), 32'(rx_start[rx_base+k] - rx_start[rx_base+k-1]), 32'(gap));
      check({tag, "_framing"}, 32'(rx_err - err_base), 32'd0);
   endtask

   // push exp_q while polling STATUS.full; stores use a random size and junk upper bits
   task automatic send_polled(input string tag, input int budget);
      int          i = 0;
      int          c = 0;
      logic [31:0] st;
      logic        s;
      logic [1:0]  be;
      while (i < exp_q.size() && c < budget) begin
         bus_rd(A_ST, st, s);
         c++;
         if (st[0] == 1'b0) begin
            be = 2'($urandom_range(0, 2));
            bus_wr(A_TX, {$urandom() & 32'hFFFF_FF00} | 32'(exp_q[i]), be);
            i++;
         end
      end
      check({tag, "_all_pushed"}, 32'(i), 32'(exp_q.size()));
   endtask

   initial begin
      int          n0, m0, lows, nb;
      logic [15:0] baud;
      logic [31:0] d;
      logic        s;

      reset_n = 1'b0; data_mem_req_i = 1'b0; data_mem_addr_i = '0; data_mem_wr_i = 1'b0;
      data_mem_wr_data_i = '0; data_mem_byte_en_i = 2'b00;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // reset state
      check("rst_tx", 32'(uart_tx_o), 32'd1);
      check("rst_irq", 32'(tx_empty_irq_o), 32'd1);
      bus_rd(A_ST, d, s);
      check("rst_status", d, 32'h0000_0002);
      check("rst_sel", 32'(s), 32'd1);
      rd_check("rst_baud", A_BAUD, 32'd868);
      rd_check("rst_txdata_read", A_TX, 32'h0);
      rx_en = 1'b1;

      // single byte, bit_len 4
      model_bl = 4;
      bus_wr(A_BAUD, 32'd4, 2'b10);
      rx_mark();
      bus_wr(A_TX, 32'h0000_00A5, 2'b00);
      n0 = wr_cyc;
      check("single_line_n1", 32'(uart_tx_o), 32'd1);
      idle_to(n0 + 5);
      check("single_irq_busy", 32'(tx_empty_irq_o), 32'd0);
      rd_check("single_status_busy", A_ST, 32'h0000_0006);
      exp_q = '{8'hA5};
      wait_rx("single", 1, 100);
      compare_rx("single", 41);
      if (rx_start.size() > rx_base)
         check("single_start_cycle", 32'(rx_start[rx_base]), 32'(n0 + 2));
      wait_idle("single", 20);
      rd_check("single_status_done", A_ST, 32'h0000_0002);

      // FIFO full / overflow, bit_len 100 (half-word baud store)
      model_bl = 100;
      bus_wr(A_BAUD, 32'd100, 2'b01);
      rx_mark();
      exp_q.delete();
      for (int i = 0; i < 9; i++) begin
         bus_wr(A_TX, 32'(i), 2'b10);
         exp_q.push_back(8'(i));
      end
      rd_check("ovf_after9", A_ST, 32'h0000_0805);
      bus_wr(A_TX, 32'h09, 2'b00);
      rd_check("ovf_after10", A_ST, 32'h0000_080D);
      bus_wr(A_ST, 32'h0000_0007, 2'b10);
      rd_check("ovf_no_clear", A_ST, 32'h0000_080D);
      bus_wr(A_ST, 32'h0000_0008, 2'b10);
      rd_check("ovf_cleared", A_ST, 32'h0000_0805);
      wait_rx("ovf", 9, 12000);
      wait_idle("ovf", 50);
      tick(50);
      compare_rx("ovf", 1001);

      // back-to-back with pointer wrap, bit_len 2
      model_bl = 2;
      bus_wr(A_BAUD, 32'd2, 2'b10);
      rx_mark();
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back(8'(8'h30 + i));
      send_polled("b2b", 2000);
      wait_rx("b2b", 20, 1000);
      compare_rx("b2b", 21);
      wait_idle("b2b", 50);

      // random payloads: first round at BAUD_DIV=0 (one cycle per bit), then a random divisor
      for (int r = 0; r < 2; r++) begin
         baud = (r == 0) ? 16'd0 : 16'($urandom_range(1, 6));
         model_bl = (baud == 16'd0) ? 1 : int'(baud);
         bus_wr(A_BAUD, ($urandom() & 32'hFFFF_0000) | 32'(baud), 2'b10);
         rd_check($sformatf("rnd%0d_baud", r), A_BAUD, 32'(baud));
         rx_mark();
         exp_q.delete();
         nb = $urandom_range(4, 12);
         for (int i = 0; i < nb; i++) exp_q.push_back(8'($urandom()));
         send_polled($sformatf("rnd%0d", r), 1000);
         wait_rx($sformatf("rnd%0d", r), nb, 1000);
         compare_rx($sformatf("rnd%0d", r), 10*model_bl + 1);
         wait_idle($sformatf("rnd%0d", r), 50);
      end

      // divisor change during data bit 3: current frame keeps 8, next uses 2
      model_bl = 8;
      bus_wr(A_BAUD, 32'd8, 2'b10);
      rx_mark();
      bus_wr(A_TX, 32'h55, 2'b00);
      n0 = wr_cyc;
      bus_wr(A_TX, 32'hC3, 2'b00);
      idle_to(n0 + 36);
      model_bl = 2;
      bus_wr(A_BAUD, 32'd2, 2'b10);
      exp_q = '{8'h55, 8'hC3};
      wait_rx("mid", 2, 400);
      compare_rx("mid", 81);
      if (rx_start.size() > rx_base)
         check("mid_start_cycle", 32'(rx_start[rx_base]), 32'(n0 + 2));
      wait_idle("mid", 50);

      // reset during data bit 5 of a frame with another byte still queued
      model_bl = 8;
      bus_wr(A_BAUD, 32'd8, 2'b10);
      bus_wr(A_TX, 32'h0F, 2'b00);
      m0 = wr_cyc;
      bus_wr(A_TX, 32'hF0, 2'b00);
      idle_to(m0 + 36);
      check("rstmid_bit3", 32'(uart_tx_o), 32'd1);
      idle_to(m0 + 52);
      check("rstmid_bit5", 32'(uart_tx_o), 32'd0);
      rx_en = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("rstmid_tx", 32'(uart_tx_o), 32'd1);
      check("rstmid_irq", 32'(tx_empty_irq_o), 32'd1);
      reset_n = 1'b1;
      rd_check("rstmid_status", A_ST, 32'h0000_0002);
      rd_check("rstmid_baud", A_BAUD, 32'd868);
      lows = 0;
      repeat (200) begin @(posedge clk); #1; if (uart_tx_o !== 1'b1) lows++; end
      check("rstmid_line_quiet", 32'(lows), 32'd0);
      rx_en = 1'b1;

      // address decode and register write rules
      bus_rd(32'h1000_0010, d, s);
      check("dec_out_rd", d, 32'h0);
      check("dec_out_sel", 32'(s), 32'd0);
      bus_rd(32'h1000_000C, d, s);
      check("dec_rsvd_rd", d, 32'h0);
      check("dec_rsvd_sel", 32'(s), 32'd1);
      rd_check("dec_lowbits_ignored", 32'h1000_0007, 32'h0000_0002);
      bus_wr(32'h1000_000C, 32'hFFFF_FFFF, 2'b10);
      rd_check("dec_rsvd_wr_status", A_ST, 32'h0000_0002);
      rd_check("dec_rsvd_wr_baud", A_BAUD, 32'd868);
      bus_wr(A_BAUD, 32'd5, 2'b00);
      rd_check("dec_byte_baud_ignored", A_BAUD, 32'd868);
      bus_wr(32'h1000_0010, 32'h41, 2'b00);
      rd_check("dec_out_wr_status", A_ST, 32'h0000_0002);
      tick(3);
      check("dec_out_wr_line", 32'(uart_tx_o), 32'd1);
      check("dec_out_wr_irq", 32'(tx_empty_irq_o), 32'd1);
      data_mem_req_i = 1'b1; data_mem_addr_i = A_ST; data_mem_wr_i = 1'b1;
      data_mem_wr_data_i = 32'h0; data_mem_byte_en_i = 2'b10;
      #1;
      check("dec_store_rd_zero", data_mem_rd_data_o, 32'h0);
      check("dec_store_sel", 32'(uart_sel_o), 32'd1);
      @(posedge clk); #1;
      data_mem_req_i = 1'b0; data_mem_wr_i = 1'b0;
      bus_wr(32'h1000_000A, 32'h0000_0003, 2'b01);
      rd_check("dec_half_baud", A_BAUD, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
